// File: rtl/mio_bus_arbiter.sv
// Two-master arbiter for the shared memory/IO bus: CPU on port 0, DMA/display fetch on port 1.
// One fixed-latency access at a time, round-robin on ties, one-cycle ready pulse to the owner.
module mio_bus_arbiter #(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int WAIT_CYCLES = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ready,
    output logic [DW-1:0] cpu_rdata,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic          dma_ready,
    output logic [DW-1:0] dma_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_w,
    input  logic [DW-1:0] mem_rdata,
    output logic          owner,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q;
    logic          last_grant_q;
    logic          owner_q;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] rdata_q;
    logic          grant_vld;
    logic          grant_dma;

    always_comb begin
        state_d   = state_q;
        grant_vld = 1'b0;
        grant_dma = 1'b0;
        case (state_q)
            IDLE: begin
                if (cpu_req || dma_req) begin
                    grant_vld = 1'b1;
                    // On a tie the master that did not win last time goes next.
                    grant_dma = dma_req && (!cpu_req || !last_grant_q);
                    state_d   = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q        <= 4'd0;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
        end else if (grant_vld) begin
            owner_q      <= grant_dma;
            last_grant_q <= grant_dma;
            we_q         <= grant_dma ? dma_we    : cpu_we;
            addr_q       <= grant_dma ? dma_addr  : cpu_addr;
            wdata_q      <= grant_dma ? dma_wdata : cpu_wdata;
            cnt_q        <= 4'(WAIT_CYCLES - 1);
        end else if (state_q == ACCESS) begin
            // Memory data is captured on the last access cycle, for writes too.
            if (cnt_q == 4'd0) begin
                rdata_q <= mem_rdata;
            end else begin
                cnt_q <= cnt_q - 4'd1;
            end
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_w     = (state_q == ACCESS) && we_q;
    assign owner     = owner_q;
    assign busy      = (state_q != IDLE);
    assign cpu_ready = (state_q == DONE) && !owner_q;
    assign dma_ready = (state_q == DONE) &&  owner_q;
    assign cpu_rdata = rdata_q;
    assign dma_rdata = rdata_q;

endmodule

// File: tb/tb_mio_bus_arbiter.sv
// Directed bench for mio_bus_arbiter: one WAIT_CYCLES=2 instance for the main scenarios,
// plus WAIT_CYCLES=1 and 15 instances sharing the same inputs for the latency check.
module tb_mio_bus_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cpu_req = 1'b0, cpu_we = 1'b0, dma_req = 1'b0, dma_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0, dma_addr = '0;
    logic [DW-1:0] cpu_wdata = '0, dma_wdata = '0, mem_rdata = '0;

    logic          cpu_ready, dma_ready, mem_w, owner, busy;
    logic [DW-1:0] cpu_rdata, dma_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;

    logic          cpu_ready_1, dma_ready_1, mem_w_1, owner_1, busy_1;
    logic [DW-1:0] cpu_rdata_1, dma_rdata_1, mem_wdata_1;
    logic [AW-1:0] mem_addr_1;

    logic          cpu_ready_15, dma_ready_15, mem_w_15, owner_15, busy_15;
    logic [DW-1:0] cpu_rdata_15, dma_rdata_15, mem_wdata_15;
    logic [AW-1:0] mem_addr_15;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mio_bus_arbiter #(.AW(AW), .DW(DW), .WAIT_CYCLES(2)) u_dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_ready(dma_ready), .dma_rdata(dma_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_w(mem_w), .mem_rdata(mem_rdata),
        .owner(owner), .busy(busy)
    );

    mio_bus_arbiter #(.AW(AW), .DW(DW), .WAIT_CYCLES(1)) u_dut_w1 (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready_1), .cpu_rdata(cpu_rdata_1),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_ready(dma_ready_1), .dma_rdata(dma_rdata_1),
        .mem_addr(mem_addr_1), .mem_wdata(mem_wdata_1), .mem_w(mem_w_1), .mem_rdata(mem_rdata),
        .owner(owner_1), .busy(busy_1)
    );

    mio_bus_arbiter #(.AW(AW), .DW(DW), .WAIT_CYCLES(15)) u_dut_w15 (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready_15), .cpu_rdata(cpu_rdata_15),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_ready(dma_ready_15), .dma_rdata(dma_rdata_15),
        .mem_addr(mem_addr_15), .mem_wdata(mem_wdata_15), .mem_w(mem_w_15), .mem_rdata(mem_rdata),
        .owner(owner_15), .busy(busy_15)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        cpu_req = 1'b0;
        dma_req = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Ticks until the named master's ready; n = edges taken, -1 on timeout.
    task automatic wait_rdy(input bit dma, output int n, output int wcnt, output int other);
        n = -1;
        wcnt = 0;
        other = 0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (mem_w) wcnt++;
            if (dma ? cpu_ready : dma_ready) other++;
            if (dma ? dma_ready : cpu_ready) begin
                n = k;
                break;
            end
        end
    endtask

    initial begin
        int n, wcnt, other;
        int lat1, lat2, lat15;
        bit exp_dma;

        // Reset state
        do_reset();
        check("rst_busy", busy, 0);
        check("rst_mem_w", mem_w, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_owner", owner, 0);
        check("rst_cpu_ready", cpu_ready, 0);
        check("rst_dma_ready", dma_ready, 0);
        check("rst_rdata", cpu_rdata, 0);

        // 1: CPU read
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h100; mem_rdata = 32'hDEADBEEF;
        wait_rdy(0, n, wcnt, other);
        check("t1_latency", n, 3);
        check("t1_mem_w_cycles", wcnt, 0);
        check("t1_dma_ready", other, 0);
        check("t1_rdata", cpu_rdata, 32'hDEADBEEF);
        check("t1_mem_addr", mem_addr, 32'h100);
        cpu_req = 1'b0;
        tick();
        check("t1_ready_one_cycle", cpu_ready, 0);
        check("t1_idle", busy, 0);

        // 2: CPU write
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h200; cpu_wdata = 32'h12345678;
        mem_rdata = 32'hCAFEF00D;
        wait_rdy(0, n, wcnt, other);
        check("t2_latency", n, 3);
        check("t2_mem_w_cycles", wcnt, 2);
        check("t2_mem_addr", mem_addr, 32'h200);
        check("t2_mem_wdata", mem_wdata, 32'h12345678);
        check("t2_mem_w_done", mem_w, 0);
        check("t2_rdata_write", cpu_rdata, 32'hCAFEF00D);
        cpu_req = 1'b0; cpu_we = 1'b0;
        tick();
        check("t2_ready_one_cycle", cpu_ready, 0);

        // 3: both requesting, alternation C,D,C,D
        do_reset();
        cpu_req = 1'b1; dma_req = 1'b1; cpu_addr = 32'h10; dma_addr = 32'h20;
        for (int g = 0; g < 4; g++) begin
            exp_dma = (g % 2 == 1);
            wait_rdy(exp_dma, n, wcnt, other);
            check($sformatf("t3_latency_%0d", g), n, (g == 0) ? 3 : 4);
            check($sformatf("t3_other_ready_%0d", g), other, 0);
            check($sformatf("t3_owner_%0d", g), owner, exp_dma);
            check($sformatf("t3_addr_%0d", g), mem_addr, exp_dma ? 32'h20 : 32'h10);
        end
        cpu_req = 1'b0; dma_req = 1'b0;

        // 4: CPU request arrives while DMA read is in flight
        do_reset();
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h300; mem_rdata = 32'h55AA55AA;
        tick();
        check("t4_owner_dma", owner, 1);
        check("t4_mem_addr", mem_addr, 32'h300);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h600;
        wait_rdy(1, n, wcnt, other);
        check("t4_dma_latency", n, 2);
        check("t4_no_cpu_ready", other, 0);
        check("t4_dma_rdata", dma_rdata, 32'h55AA55AA);
        dma_req = 1'b0; mem_rdata = 32'h11112222;
        wait_rdy(0, n, wcnt, other);
        check("t4_cpu_latency", n, 4);
        check("t4_owner_cpu", owner, 0);
        check("t4_cpu_addr", mem_addr, 32'h600);
        check("t4_cpu_rdata", cpu_rdata, 32'h11112222);
        cpu_req = 1'b0;

        // 5: reset in the second access cycle of a write
        do_reset();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h400; cpu_wdata = 32'h0000A5A5;
        tick();
        tick();
        check("t5_mem_w_pre", mem_w, 1);
        reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0;
        tick();
        check("t5_mem_w", mem_w, 0);
        check("t5_busy", busy, 0);
        check("t5_cpu_ready", cpu_ready, 0);
        check("t5_mem_addr", mem_addr, 0);
        reset = 1'b0;
        tick();
        tick();
        check("t5_no_late_ready", cpu_ready, 0);
        cpu_req = 1'b1; cpu_addr = 32'h500; mem_rdata = 32'h0BADF00D;
        wait_rdy(0, n, wcnt, other);
        check("t5_after_latency", n, 3);
        check("t5_after_rdata", cpu_rdata, 32'h0BADF00D);
        check("t5_after_mem_w", wcnt, 0);
        cpu_req = 1'b0;

        // 6: WAIT_CYCLES 1 / 2 / 15 latency
        do_reset();
        lat1 = -1; lat2 = -1; lat15 = -1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h700;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (cpu_ready_1  && lat1  < 0) lat1  = k;
            if (cpu_ready    && lat2  < 0) lat2  = k;
            if (cpu_ready_15 && lat15 < 0) lat15 = k;
        end
        cpu_req = 1'b0;
        check("t6_latency_w1", lat1, 2);
        check("t6_latency_w2", lat2, 3);
        check("t6_latency_w15", lat15, 16);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
